digit_pulse_gen: RTL and testbench
==================================

Name: digit_pulse_gen

Overview:
- Upstream timing source for the control section: generates the digit-pulse and minor-cycle timing that ccu_2 and sibling CCUs gate with.
- Produces the d0 and d35 digit pulses, the even/odd minor-cycle d0 pulses (ev_d0, od_d0), and major-cycle boundary markers.
- Starts and stops cleanly on major-cycle boundaries under run/step control, so downstream flipflop/delay chains never see a truncated cycle.

Parameters:
- DIGITS_PER_MC, 36, pulse intervals per minor cycle (M/C); 36 p.i. = 1 M/C.
- MC_PER_MAJOR, 16, minor cycles per major cycle.
- DW, $clog2(DIGITS_PER_MC), derived digit-counter width (6 at default).
- MW, $clog2(MC_PER_MAJOR), derived minor-cycle-counter width (4 at default).

Ports:
- clk  input  1  pulse-interval clock; one edge = one p.i.
- rst_n  input  1  reset, asynchronous, active-low.
- run  input  1  level; 1 = run continuously, 0 = stop at the next major-cycle end.
- step  input  1  single-cycle pulse; while idle, runs exactly one major cycle.
- running  output  1  timing active.
- digit  output  DW  current digit position, 0..DIGITS_PER_MC-1.
- mc  output  MW  current minor cycle, 0..MC_PER_MAJOR-1.
- d0  output  1  digit 0 of every minor cycle.
- d35  output  1  last digit (DIGITS_PER_MC-1) of every minor cycle.
- ev_d0  output  1  d0 in an even minor cycle (mc[0]==0).
- od_d0  output  1  d0 in an odd minor cycle.
- major_start  output  1  d0 of minor cycle 0.
- major_end  output  1  d35 of minor cycle MC_PER_MAJOR-1.

Behaviour:
- State: registers digit, mc, running, plus a one-bit single-shot flag (ss).
- All decoded outputs are combinational from registered state and are gated by running, so every pulse is 0 while idle.
- Reset (rst_n=0, asynchronous): digit=0, mc=0, running=0, ss=0, so all pulse outputs are 0. Reset mid-cycle aborts immediately; there is no completion.
- Idle (running=0): counters hold 0.
  - run=1 sampled at an edge: running=1 from that edge, ss=0.
  - Otherwise step=1 sampled at an edge: running=1 and ss=1.
  - Run has priority when run and step are both 1.
- First running cycle is digit=0, mc=0, so d0, ev_d0 and major_start are all 1. Latency from run/step sample to first d0 is 0 cycles after the sampling edge.
- Running, at each edge:
  - digit increments, wrapping from DIGITS_PER_MC-1 to 0.
  - On that wrap, mc increments, wrapping from MC_PER_MAJOR-1 to 0.
- Decode:
  - d0 = running & digit==0.
  - d35 = running & digit==DIGITS_PER_MC-1.
  - ev_d0 = d0 & ~mc[0].
  - od_d0 = d0 & mc[0].
  - major_start = d0 & mc==0.
  - major_end = d35 & mc==MC_PER_MAJOR-1.
- Stop decision is made only at the edge that ends a major_end cycle.
  - Stop if (ss=1 and run=0) or (ss=0 and run=0): running becomes 0, counters return to 0, ss becomes 0.
  - If run=1 at that edge: continue seamlessly into the next major cycle with no gap and ss becomes 0. Raising run during a single-shot therefore converts it to continuous running.
- Dropping run mid-major-cycle does not stop early; the current major cycle always completes. Toggling run within a major cycle has no effect except its value at the major_end edge.
- step while running is ignored.
- step held high for several cycles while idle starts only one cycle. A step still high at the major_end edge of a single-shot does not restart; re-arming requires step low for at least one idle cycle.
- Exactly one of ev_d0/od_d0 pulses per minor cycle. They alternate, with ev_d0 first in each major cycle (MC_PER_MAJOR even at default).
- Period at default: 36 p.i. per minor cycle, 576 p.i. per major cycle.

Test Plan:
- Reset then idle, run=0, step=0 for 100 clk: running=0; all pulses 0; digit=0; mc=0.
- Assert run=1 and hold: d0 at clk 0, 36, 72…; d35 at clk 35, 71…; ev_d0 at 0, 72; od_d0 at 36, 108; major_start at 0, 576; major_end at 575, 1151.
- Run continuously, drop run at clk 100: pulses continue through major_end at clk 575; running=0 from clk 576; no further d0.
- Idle, 1-cycle step pulse: exactly 16 d0, 8 ev_d0, 8 od_d0 and 1 major_end, then running=0 after 576 clk. Holding step high for 1000 clk yields only one major cycle.
- During a single-shot, raise run at clk 300: no gap at clk 576 (major_start=1), running continues.
- Continuous run, pull rst_n low at digit=17, mc=5 (asynchronously, between edges): outputs go 0 immediately. After release with run=1, the first cycle is digit=0, mc=0, major_start=1.

Source files
------------

// File: rtl/digit_pulse_gen.sv
// Digit-pulse / minor-cycle timing generator. Runs whole major cycles under
// run/step control and decodes d0, d35, ev_d0, od_d0 and major-cycle markers.
module digit_pulse_gen #(
  parameter int DIGITS_PER_MC = 36,
  parameter int MC_PER_MAJOR  = 16,
  parameter int DW            = $clog2(DIGITS_PER_MC),
  parameter int MW            = $clog2(MC_PER_MAJOR)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          step,
  output logic          running,
  output logic [DW-1:0] digit,
  output logic [MW-1:0] mc,
  output logic          d0,
  output logic          d35,
  output logic          ev_d0,
  output logic          od_d0,
  output logic          major_start,
  output logic          major_end
);

  localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS_PER_MC - 1);
  localparam logic [MW-1:0] LAST_MC    = MW'(MC_PER_MAJOR - 1);

  // ST_SHOT is the single-shot flag (ss=1); ST_CONT is continuous running.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONT = 2'd1,
    ST_SHOT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_digit;
  logic [DW-1:0]   w_digit_nxt;
  logic [MW-1:0]   r_mc;
  logic [MW-1:0]   w_mc_nxt;
  logic            r_armed;
  logic            w_armed_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_digit <= '0;
      r_mc    <= '0;
      r_armed <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_digit <= w_digit_nxt;
      r_mc    <= w_mc_nxt;
      r_armed <= w_armed_nxt;
    end
  end

  // r_armed blocks a step that is still held from restarting; it is set
  // again only after step is seen low while idle.
  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    w_mc_nxt    = r_mc;
    w_armed_nxt = r_armed;
    case (r_state)
      ST_IDLE: begin
        w_digit_nxt = '0;
        w_mc_nxt    = '0;
        if (!step) w_armed_nxt = 1'b1;
        if (run) begin
          w_state_nxt = ST_CONT;
        end else if (step && r_armed) begin
          w_state_nxt = ST_SHOT;
          w_armed_nxt = 1'b0;
        end
      end
      ST_CONT, ST_SHOT: begin
        if (r_digit == LAST_DIGIT) begin
          w_digit_nxt = '0;
          if (r_mc == LAST_MC) begin
            w_mc_nxt    = '0;
            w_state_nxt = run ? ST_CONT : ST_IDLE;
          end else begin
            w_mc_nxt = r_mc + MW'(1);
          end
        end else begin
          w_digit_nxt = r_digit + DW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_digit_nxt = '0;
        w_mc_nxt    = '0;
      end
    endcase
  end

  assign running     = (r_state != ST_IDLE);
  assign digit       = r_digit;
  assign mc          = r_mc;
  assign d0          = running && (r_digit == '0);
  assign d35         = running && (r_digit == LAST_DIGIT);
  assign ev_d0       = d0 && !r_mc[0];
  assign od_d0       = d0 && r_mc[0];
  assign major_start = d0 && (r_mc == '0);
  assign major_end   = d35 && (r_mc == LAST_MC);

endmodule

// File: tb/tb_digit_pulse_gen.sv
// Scoreboard bench for digit_pulse_gen: a position-in-major-cycle reference
// model predicts every cycle's outputs; a negedge monitor compares them.
module tb_digit_pulse_gen;

  localparam int DPM = 36;
  localparam int MPM = 16;
  localparam int MAJ = DPM * MPM;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       step;
  logic       running;
  logic [5:0] digit;
  logic [3:0] mc;
  logic       d0, d35, ev_d0, od_d0, major_start, major_end;

  digit_pulse_gen dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .running(running), .digit(digit), .mc(mc),
    .d0(d0), .d35(d35), .ev_d0(ev_d0), .od_d0(od_d0),
    .major_start(major_start), .major_end(major_end)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Timing is a position 0..MAJ-1 inside the major cycle.
  bit m_run;
  bit m_ss;
  bit m_armed;
  int m_pos;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  int cnt_d0, cnt_ev, cnt_od, cnt_me;

  function automatic logic [16:0] model_out();
    int d, m;
    logic [5:0] dv;
    logic [3:0] mv;
    logic p0, p35;
    if (!m_run) return '0;
    d   = m_pos % DPM;
    m   = m_pos / DPM;
    dv  = 6'(d);
    mv  = 4'(m);
    p0  = (d == 0);
    p35 = (d == DPM - 1);
    return {1'b1, dv, mv, p0, p35, p0 && (m % 2 == 0), p0 && (m % 2 == 1),
            p0 && (m == 0), p35 && (m == MPM - 1)};
  endfunction

  task automatic model_reset();
    m_run = 0; m_ss = 0; m_armed = 1; m_pos = 0;
  endtask

  task automatic model_edge(input bit r, input bit s);
    if (!m_run) begin
      m_pos = 0;
      if (r) begin
        m_run = 1; m_ss = 0;
      end else if (s && m_armed) begin
        m_run = 1; m_ss = 1; m_armed = 0;
      end
      if (!s) m_armed = 1;
    end else if (m_pos == MAJ - 1) begin
      m_pos = 0;
      m_ss  = 0;
      if (!r) m_run = 0;
    end else begin
      m_pos = m_pos + 1;
    end
  endtask

  function automatic logic [16:0] dut_vec();
    return {running, digit, mc, d0, d35, ev_d0, od_d0, major_start, major_end};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [16:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = dut_vec();
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, act_v, exp_v);
        end
        cnt_d0 += int'(d0);
        cnt_ev += int'(ev_d0);
        cnt_od += int'(od_d0);
        cnt_me += int'(major_end);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit r, input bit s);
    @(posedge clk);
    #1;
    exp_q.push_back(model_out());
    run  = r;
    step = s;
    model_edge(r, s);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    @(posedge clk);
    cnt_d0 = 0; cnt_ev = 0; cnt_od = 0; cnt_me = 0;
  endtask

  task automatic async_reset_mid_run();
    @(posedge clk);
    #1;
    check("pre_reset_digit", int'(digit), 17);
    check("pre_reset_mc", int'(mc), 5);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_running", int'(running), 0);
    check("async_reset_pulses", int'({d0, d35, ev_d0, od_d0, major_start, major_end}), 0);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    exp_q.push_back(model_out());
    rst_n = 1'b1;
    run   = 1'b1;
    model_edge(1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit rr, ss;
    int guard;
    rst_n = 1'b0; run = 1'b0; step = 1'b0;
    cnt_d0 = 0; cnt_ev = 0; cnt_od = 0; cnt_me = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_running", int'(running), 0);
    check("reset_digit", int'(digit), 0);
    check("reset_mc", int'(mc), 0);
    rst_n = 1'b1;

    // Idle with no control.
    idle_cycles(100);

    // Continuous run for two major cycles, then let it stop.
    for (int i = 0; i < 2 * MAJ; i++) cycle(1'b1, 1'b0);
    idle_cycles(MAJ + 20);

    // Drop run early: the major cycle still completes.
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0);
    idle_cycles(MAJ + 50);

    // Single-cycle step: exactly one major cycle.
    clear_counts();
    cycle(1'b0, 1'b1);
    idle_cycles(MAJ + 20);
    repeat (2) @(negedge clk);
    check("shot_d0_count", cnt_d0, MPM);
    check("shot_ev_count", cnt_ev, MPM / 2);
    check("shot_od_count", cnt_od, MPM / 2);
    check("shot_major_end_count", cnt_me, 1);

    // Step held high for 1000 cycles: only one major cycle.
    clear_counts();
    for (int i = 0; i < 1000; i++) cycle(1'b0, 1'b1);
    idle_cycles(10);
    repeat (2) @(negedge clk);
    check("held_step_major_end_count", cnt_me, 1);
    check("held_step_d0_count", cnt_d0, MPM);

    // Single shot converted to continuous by raising run mid-cycle.
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 299; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 400; i++) cycle(1'b1, 1'b0);
    idle_cycles(MAJ + 20);

    // Asynchronous reset at digit 17 of minor cycle 5.
    guard = 0;
    cycle(1'b1, 1'b0);
    while (m_pos != 5 * DPM + 17 && guard < 2 * MAJ) begin
      cycle(1'b1, 1'b0);
      guard++;
    end
    check("reach_reset_point_in_budget", int'(guard < 2 * MAJ), 1);
    async_reset_mid_run();
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b0);
    idle_cycles(MAJ + 10);

    // Randomised run/step traffic.
    rr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) rr = ~rr;
      ss = ($urandom_range(0, 39) == 0);
      cycle(rr, ss);
    end
    idle_cycles(MAJ + 10);

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
